// File: rtl/sram_map_pkg.sv
// Address map shared by the data_sram responder and its config-register block.
// Latency: none (types, constants and pure functions only).
// Backpressure: not applicable.
package sram_map_pkg;

   localparam int          RAM_AW_DEF  = 10;
   localparam logic [15:0] CONF_HI_DEF = 16'hBFAF;

   // Offsets inside the config window (addr[15:0])
   localparam logic [15:0] OFF_TIMER  = 16'hE000;
   localparam logic [15:0] OFF_LED    = 16'hF000;
   localparam logic [15:0] OFF_SWITCH = 16'hF010;
   localparam logic [15:0] OFF_NUM    = 16'hF020;

   typedef enum logic [2:0] {
      REG_NONE,
      REG_TIMER,
      REG_LED,
      REG_SWITCH,
      REG_NUM
   } conf_reg_e;

   function automatic conf_reg_e decode_offset(input logic [15:0] off);
      conf_reg_e sel;
      case (off)
         OFF_TIMER:  sel = REG_TIMER;
         OFF_LED:    sel = REG_LED;
         OFF_SWITCH: sel = REG_SWITCH;
         OFF_NUM:    sel = REG_NUM;
         default:    sel = REG_NONE;
      endcase
      return sel;
   endfunction

   // Replace the byte lanes of old_val whose write enable is set.
   function automatic logic [31:0] merge_bytes(input logic [31:0] old_val,
                                               input logic [31:0] new_val,
                                               input logic [3:0]  wen);
      logic [31:0] merged;
      for (int i = 0; i < 4; i++) begin
         merged[8*i +: 8] = wen[i] ? new_val[8*i +: 8] : old_val[8*i +: 8];
      end
      return merged;
   endfunction

endpackage

// File: rtl/conf_regs.sv
// Config-register window: free-running timer, LED, 7-seg number, synchronized switches.
// Latency: writes commit at the clock edge; rdata is combinational from current register state.
// Backpressure: none, every access is accepted.
// Ports: clk/resetn; wr strobe with wen/offset/wdata; switch_in (async pins);
//        rdata (combinational read mux); led_out, num_out (register outputs).
module conf_regs
   import sram_map_pkg::*;
(
   input  logic        clk,
   input  logic        resetn,
   input  logic        wr,
   input  logic [3:0]  wen,
   input  logic [15:0] offset,
   input  logic [31:0] wdata,
   input  logic [7:0]  switch_in,
   output logic [31:0] rdata,
   output logic [15:0] led_out,
   output logic [31:0] num_out
);

   conf_reg_e   sel;
   logic [31:0] timer;
   logic [15:0] led;
   logic [31:0] num;
   logic [7:0]  sw_meta;
   logic [7:0]  sw_sync;
   logic [15:0] led_next;

   assign sel = decode_offset(offset);

   // LED is 16 bits wide, so only lanes 0 and 1 can reach it
   assign led_next = {wen[1] ? wdata[15:8] : led[15:8],
                      wen[0] ? wdata[7:0]  : led[7:0]};

   always_ff @(posedge clk) begin
      if (!resetn) begin
         timer   <= '0;
         led     <= '0;
         num     <= '0;
         sw_meta <= '0;
         sw_sync <= '0;
      end else begin
         sw_meta <= switch_in;
         sw_sync <= sw_meta;
         // A timer write overrides that cycle's increment
         if (wr && sel == REG_TIMER) begin
            timer <= merge_bytes(timer, wdata, wen);
         end else begin
            timer <= timer + 32'd1;
         end
         if (wr && sel == REG_LED) begin
            led <= led_next;
         end
         if (wr && sel == REG_NUM) begin
            num <= merge_bytes(num, wdata, wen);
         end
      end
   end

   always_comb begin
      rdata = '0;
      case (sel)
         REG_TIMER:  rdata = timer;
         REG_LED:    rdata = {16'h0000, led};
         REG_SWITCH: rdata = {24'h000000, sw_sync};
         REG_NUM:    rdata = num;
         default:    rdata = '0;
      endcase
   end

   assign led_out = led;
   assign num_out = num;

endmodule

// File: rtl/data_sram_responder.sv
// Responder for the CPU data_sram port: byte-writable word RAM plus a config-register window.
// Latency: reads return on data_sram_rdata one cycle after the request; writes commit at the edge.
// Backpressure: none, every request is accepted and there is no ready signal.
// Ports: clk/resetn; data_sram_en/wen/addr/wdata request; data_sram_rdata registered response;
//        switch_in board switches; led_out, num_out board outputs.
module data_sram_responder
   import sram_map_pkg::*;
#(
   parameter int          RAM_AW  = RAM_AW_DEF,
   parameter logic [15:0] CONF_HI = CONF_HI_DEF
)
(
   input  logic        clk,
   input  logic        resetn,
   input  logic        data_sram_en,
   input  logic [3:0]  data_sram_wen,
   input  logic [31:0] data_sram_addr,
   input  logic [31:0] data_sram_wdata,
   output logic [31:0] data_sram_rdata,
   input  logic [7:0]  switch_in,
   output logic [15:0] led_out,
   output logic [31:0] num_out
);

   logic              is_conf;
   logic              rd;
   logic              wr;
   logic [RAM_AW-1:0] word;
   logic [15:0]       conf_offset;
   logic [31:0]       conf_rdata;
   logic              unused_byte_offset;

   logic [31:0] mem [0:(1<<RAM_AW)-1];

   assign is_conf     = (data_sram_addr[31:16] == CONF_HI);
   assign rd          = data_sram_en && (data_sram_wen == 4'd0);
   assign wr          = data_sram_en && (data_sram_wen != 4'd0);
   // Address bits above the RAM depth alias onto the same words
   assign word        = data_sram_addr[RAM_AW+1:2];
   assign conf_offset = {data_sram_addr[15:2], 2'b00};
   assign unused_byte_offset = ^data_sram_addr[1:0];

   conf_regs u_conf_regs (
      .clk       (clk),
      .resetn    (resetn),
      .wr        (wr && is_conf),
      .wen       (data_sram_wen),
      .offset    (conf_offset),
      .wdata     (data_sram_wdata),
      .switch_in (switch_in),
      .rdata     (conf_rdata),
      .led_out   (led_out),
      .num_out   (num_out)
   );

   // RAM contents are deliberately not reset
   always_ff @(posedge clk) begin
      if (wr && !is_conf) begin
         for (int i = 0; i < 4; i++) begin
            if (data_sram_wen[i]) begin
               mem[word][8*i +: 8] <= data_sram_wdata[8*i +: 8];
            end
         end
      end
   end

   // rdata only changes on a read; writes and idle cycles leave it holding
   always_ff @(posedge clk) begin
      if (!resetn) begin
         data_sram_rdata <= '0;
      end else if (rd) begin
         data_sram_rdata <= is_conf ? conf_rdata : mem[word];
      end
   end

endmodule

// File: tb/tb_data_sram_responder.sv
module tb_data_sram_responder;

   localparam logic [31:0] A_RAM    = 32'h0000_0010;
   localparam logic [31:0] A_ALIAS  = 32'h0000_1010;
   localparam logic [31:0] A_TIMER  = 32'hBFAF_E000;
   localparam logic [31:0] A_LED    = 32'hBFAF_F000;
   localparam logic [31:0] A_SWITCH = 32'hBFAF_F010;
   localparam logic [31:0] A_NUM    = 32'hBFAF_F020;
   localparam logic [31:0] A_UNMAP  = 32'hBFAF_0004;

   logic        clk = 1'b0;
   logic        resetn;
   logic        data_sram_en;
   logic [3:0]  data_sram_wen;
   logic [31:0] data_sram_addr;
   logic [31:0] data_sram_wdata;
   logic [31:0] data_sram_rdata;
   logic [7:0]  switch_in;
   logic [15:0] led_out;
   logic [31:0] num_out;

   int          n_checks = 0;
   int          n_errors = 0;
   logic [31:0] sb[$];
   logic [31:0] last_rd;

   always #5 clk = ~clk;

   data_sram_responder dut (
      .clk             (clk),
      .resetn          (resetn),
      .data_sram_en    (data_sram_en),
      .data_sram_wen   (data_sram_wen),
      .data_sram_addr  (data_sram_addr),
      .data_sram_wdata (data_sram_wdata),
      .data_sram_rdata (data_sram_rdata),
      .switch_in       (switch_in),
      .led_out         (led_out),
      .num_out         (num_out)
   );

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_checks++;
      assert (obs === exp) else begin
         n_errors++;
         $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   task automatic drive(input logic e, input logic [3:0] w, input logic [31:0] a,
                        input logic [31:0] d);
      @(negedge clk);
      data_sram_en    = e;
      data_sram_wen   = w;
      data_sram_addr  = a;
      data_sram_wdata = d;
   endtask

   task automatic do_write(input logic [31:0] a, input logic [3:0] w, input logic [31:0] d);
      drive(1'b1, w, a, d);
      @(posedge clk);
   endtask

   // Expected value goes into the scoreboard when the request is driven,
   // and is popped when the response appears one edge later.
   task automatic do_read(input string tag, input logic [31:0] a, input logic [31:0] exp);
      drive(1'b1, 4'd0, a, 32'd0);
      sb.push_back(exp);
      @(posedge clk);
      #1;
      if (sb.size() == 0) begin
         n_checks++;
         n_errors++;
         $error("FAIL %s observed=empty_scoreboard expected=entry", tag);
      end else begin
         last_rd = sb.pop_front();
         check(tag, data_sram_rdata, last_rd);
      end
   endtask

   task automatic idle(input int n);
      drive(1'b0, 4'd0, 32'd0, 32'd0);
      repeat (n) @(posedge clk);
   endtask

   task automatic apply_reset();
      @(negedge clk);
      resetn       = 1'b0;
      data_sram_en = 1'b0;
      repeat (2) @(posedge clk);
      @(negedge clk);
      resetn = 1'b1;
   endtask

   initial begin
      resetn          = 1'b0;
      data_sram_en    = 1'b0;
      data_sram_wen   = 4'd0;
      data_sram_addr  = 32'd0;
      data_sram_wdata = 32'd0;
      switch_in       = 8'h00;
      last_rd         = 32'd0;

      // Reset state
      apply_reset();
      #1;
      check("reset_rdata", data_sram_rdata, 32'd0);
      check("reset_led", {16'd0, led_out}, 32'd0);
      check("reset_num", num_out, 32'd0);

      // 1: full-word write, read on the very next cycle
      do_write(A_RAM, 4'hF, 32'hDEADBEEF);
      do_read("raw_full_word", A_RAM, 32'hDEADBEEF);
      idle(3);
      #1;
      check("rdata_hold_idle", data_sram_rdata, last_rd);

      // 2: partial byte-lane write
      do_write(A_RAM, 4'b0101, 32'h11223344);
      #1;
      check("rdata_hold_write", data_sram_rdata, 32'hDEADBEEF);
      do_read("byte_merge", A_RAM, 32'hDE22BE44);
      do_read("ram_alias", A_ALIAS, 32'hDE22BE44);

      // 3: timer counts from reset, then wraps
      apply_reset();
      repeat (100) @(posedge clk);
      do_read("timer_100", A_TIMER, 32'd100);
      do_write(A_TIMER, 4'hF, 32'hFFFFFFFF);
      idle(2);
      do_read("timer_wrap", A_TIMER, 32'd1);

      // 4: LED and NUM registers
      do_write(A_LED, 4'hF, 32'hABCD1234);
      #1;
      check("led_out_write", {16'd0, led_out}, 32'h0000_1234);
      do_read("led_read", A_LED, 32'h0000_1234);
      do_write(A_LED, 4'b0010, 32'h0000_7700);
      #1;
      check("led_lane1_only", {16'd0, led_out}, 32'h0000_7734);
      do_write(A_NUM, 4'hF, 32'h0000_005A);
      #1;
      check("num_out_write", num_out, 32'h0000_005A);
      do_read("num_read", A_NUM, 32'h0000_005A);

      // 5: switches, unmapped offsets
      switch_in = 8'hA5;
      idle(2);
      #1;
      check("led_unchanged_by_switch", {16'd0, led_out}, 32'h0000_7734);
      do_read("switch_read", A_SWITCH, 32'h0000_00A5);
      do_write(A_SWITCH, 4'hF, 32'h0000_0000);
      do_read("switch_ro", A_SWITCH, 32'h0000_00A5);
      do_read("unmapped_read", A_UNMAP, 32'd0);
      do_write(A_UNMAP, 4'hF, 32'hFFFF_FFFF);
      do_read("unmapped_after_write", A_UNMAP, 32'd0);

      // 6: reset arriving right behind a read
      do_read("pre_reset_ram", A_RAM, 32'hDE22BE44);
      @(negedge clk);
      resetn = 1'b0;
      @(posedge clk);
      #1;
      check("mid_reset_rdata", data_sram_rdata, 32'd0);
      check("mid_reset_led", {16'd0, led_out}, 32'd0);
      check("mid_reset_num", num_out, 32'd0);
      @(posedge clk);
      @(negedge clk);
      resetn          = 1'b1;
      data_sram_en    = 1'b1;
      data_sram_wen   = 4'd0;
      data_sram_addr  = A_TIMER;
      sb.push_back(32'd0);
      @(posedge clk);
      #1;
      last_rd = sb.pop_front();
      check("timer_after_reset", data_sram_rdata, last_rd);
      do_read("ram_survives_reset", A_RAM, 32'hDE22BE44);
      idle(1);

      if (sb.size() != 0) begin
         n_checks++;
         n_errors++;
         $error("FAIL scoreboard_drain observed=%0d expected=0", sb.size());
      end

      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end

endmodule
